// File: rtl/hwpe_instr_seq.sv
// HWPE conv-layer command sequencer: streams reset, config, feature-load, clear, matrix and
// per-tile accumulator readout commands. Define HWPE_SEQ_RELU_EN to add the relu readout variant.
module hwpe_instr_seq #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned PES      = 16,
    parameter int unsigned NUM_BASE = 8,
    parameter logic [6:0]  OPCODE   = 7'b0001011
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             cfg0,
    input  logic [31:0]             cfg1,
    input  logic [31:0]             cfg_mat_vrs1,
    input  logic [31:0]             cfg_mat_vrs2,
    input  logic [NUM_BASE*32-1:0]  cfg_base,
    input  logic [31:0]             cfg_relu_addr,
    input  logic                    cfg_relu_mode,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [31:0]             cmd_instr,
    output logic [31:0]             cmd_rs1,
    output logic [31:0]             cmd_rs2,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned      NUM_FAD  = NUM_BASE / 2;
    localparam int unsigned      FAD_W    = (NUM_FAD > 1) ? $clog2(NUM_FAD) : 1;
    localparam logic [2:0]       ROW_LAST = 3'(ROWS - 1);
    localparam logic [4:0]       PE_LAST  = 5'(PES - 1);
    localparam logic [FAD_W-1:0] FAD_LAST = FAD_W'(NUM_FAD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WCFG, S_WFAD, S_WACC, S_MATRIX, S_READ, S_DONE
    } state_e;

    typedef struct packed {
        logic [31:0]            cfg0;
        logic [31:0]            cfg1;
        logic [31:0]            vrs1;
        logic [31:0]            vrs2;
        logic [NUM_BASE*32-1:0] base;
`ifdef HWPE_SEQ_RELU_EN
        logic [31:0]            relu_addr;
        logic                   relu_mode;
`endif
    } cfg_t;

    function automatic logic [31:0] enc(input logic [6:0] funct7, input logic [4:0] rs2f,
                                        input logic [4:0] rs1f, input logic [2:0] xflags,
                                        input logic [4:0] rd);
        return {funct7, rs2f, rs1f, xflags, rd, OPCODE};
    endfunction

    state_e           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic [9:0]       k_q, k_d;
    logic [15:0]      w_q, w_d;
    logic [15:0]      h_q, h_d;
    logic [2:0]       row_q, row_d;
    logic [4:0]       pe_q, pe_d;
    logic [FAD_W-1:0] fad_q, fad_d;

    logic        hs;
    logic        relu_mode;
    logic [9:0]  k_cnt;
    logic [15:0] w_cnt, h_cnt;
    logic        last_tile, tile_item_last, counts_zero;
    logic [4:0]  acc;

    assign cmd_valid = (state_q != S_IDLE) && (state_q != S_DONE);
    assign busy      = cmd_valid;
    assign done      = (state_q == S_DONE);
    assign hs        = cmd_valid && cmd_ready;

`ifdef HWPE_SEQ_RELU_EN
    assign relu_mode = cfg_q.relu_mode;
`else
    logic unused_relu;
    assign relu_mode   = 1'b0;
    assign unused_relu = ^{cfg_relu_mode, cfg_relu_addr};
`endif

    assign k_cnt       = cfg_q.cfg1[22:13];
    assign w_cnt       = cfg_q.vrs1[31:16];
    assign h_cnt       = cfg_q.vrs1[15:0];
    assign counts_zero = (k_cnt == '0) || (w_cnt == '0) || (h_cnt == '0);
    assign last_tile   = (k_q == k_cnt - 10'd1) && (w_q == w_cnt - 16'd1) && (h_q == h_cnt - 16'd1);

    // A tile ends on its last row (and, for racc, its last PE); all but the layer's final tile mark it.
    assign tile_item_last = (row_q == ROW_LAST) && (relu_mode || (pe_q == PE_LAST));
    assign acc = (tile_item_last && !last_tile) ? {2'b10, row_q} : {2'b00, row_q};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d   = state_q;
        cfg_d     = cfg_q;
        k_d       = k_q;
        w_d       = w_q;
        h_d       = h_q;
        row_d     = row_q;
        pe_d      = pe_q;
        fad_d     = fad_q;
        cmd_instr = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d.cfg0 = cfg0;
                    cfg_d.cfg1 = cfg1;
                    cfg_d.vrs1 = cfg_mat_vrs1;
                    cfg_d.vrs2 = cfg_mat_vrs2;
                    cfg_d.base = cfg_base;
`ifdef HWPE_SEQ_RELU_EN
                    cfg_d.relu_addr = cfg_relu_addr;
                    cfg_d.relu_mode = cfg_relu_mode;
`endif
                    {k_d, w_d, h_d, row_d, pe_d, fad_d} = '0;
                    state_d = S_RST;
                end
            end
            S_RST: begin
                cmd_instr = enc(7'd64, 5'd0, 5'd0, 3'b000, 5'd0);
                if (hs) state_d = S_WCFG;
            end
            S_WCFG: begin
                cmd_instr = enc(7'd2, 5'd0, 5'd0, 3'b011, 5'd0);
                cmd_rs1   = cfg_q.cfg0;
                cmd_rs2   = cfg_q.cfg1;
                if (hs) state_d = S_WFAD;
            end
            S_WFAD: begin
                cmd_instr = enc(7'd1, 5'd0, 5'd0, 3'b011, 5'({fad_q, 1'b0}));
                for (int i = 0; i < int'(NUM_FAD); i++) begin
                    if (fad_q == FAD_W'(i)) begin
                        cmd_rs1 = cfg_q.base[64*i +: 32];
                        cmd_rs2 = cfg_q.base[64*i+32 +: 32];
                    end
                end
                if (hs) begin
                    if (fad_q == FAD_LAST) begin
                        fad_d   = '0;
                        state_d = S_WACC;
                    end else begin
                        fad_d = fad_q + 1'b1;
                    end
                end
            end
            S_WACC: begin
                cmd_instr = enc(7'd8, pe_q, 5'd0, 3'b010, {2'b00, row_q});
                if (hs) begin
                    if (pe_q != PE_LAST) begin
                        pe_d = pe_q + 5'd1;
                    end else begin
                        pe_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_MATRIX;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end
                end
            end
            S_MATRIX: begin
                cmd_instr = enc(7'd4, 5'd0, 5'd0, 3'b011, 5'd0);
                cmd_rs1   = cfg_q.vrs1;
                cmd_rs2   = cfg_q.vrs2;
                if (hs) state_d = counts_zero ? S_DONE : S_READ;
            end
            S_READ: begin
`ifdef HWPE_SEQ_RELU_EN
                if (relu_mode) begin
                    cmd_instr = enc(7'd32, acc, 5'd0, 3'b010, 5'd0);
                    cmd_rs1   = cfg_q.relu_addr;
                end else begin
                    cmd_instr = enc(7'd16, pe_q, acc, 3'b100, 5'd0);
                end
`else
                cmd_instr = enc(7'd16, pe_q, acc, 3'b100, 5'd0);
`endif
                if (hs) begin
                    if (tile_item_last) begin
                        row_d = '0;
                        pe_d  = '0;
                        if (last_tile) begin
                            {k_d, w_d, h_d} = '0;
                            state_d = S_DONE;
                        end else if (h_q != h_cnt - 16'd1) begin
                            h_d = h_q + 16'd1;
                        end else begin
                            h_d = '0;
                            if (w_q != w_cnt - 16'd1) begin
                                w_d = w_q + 16'd1;
                            end else begin
                                w_d = '0;
                                k_d = k_q + 10'd1;
                            end
                        end
                    end else if (!relu_mode && (pe_q != PE_LAST)) begin
                        pe_d = pe_q + 5'd1;
                    end else begin
                        pe_d  = '0;
                        row_d = row_q + 3'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (rst) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            k_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            pe_q    <= '0;
            fad_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            k_q     <= k_d;
            w_q     <= w_d;
            h_q     <= h_d;
            row_q   <= row_d;
            pe_q    <= pe_d;
            fad_q   <= fad_d;
        end
    end

endmodule

// File: tb/tb_hwpe_instr_seq.sv
// Self-checking bench for hwpe_instr_seq: a loop-level model of the layer command stream is
// compared against every accepted command; literal expectations pin counts and marker positions.
`timescale 1ns/1ps
module tb_hwpe_instr_seq;

    localparam int ROWS     = 8;
    localparam int PES      = 16;
    localparam int NUM_BASE = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [31:0]            cfg0, cfg1, cfg_mat_vrs1, cfg_mat_vrs2, cfg_relu_addr;
    logic [NUM_BASE*32-1:0] cfg_base;
    logic                   cfg_relu_mode;
    logic                   cmd_valid;
    logic                   cmd_ready = 1'b1;
    logic [31:0]            cmd_instr, cmd_rs1, cmd_rs2;
    logic                   busy, done;

    hwpe_instr_seq #(.ROWS(ROWS), .PES(PES), .NUM_BASE(NUM_BASE), .OPCODE(7'b0001011)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg0(cfg0), .cfg1(cfg1), .cfg_mat_vrs1(cfg_mat_vrs1), .cfg_mat_vrs2(cfg_mat_vrs2),
        .cfg_base(cfg_base), .cfg_relu_addr(cfg_relu_addr), .cfg_relu_mode(cfg_relu_mode),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef logic [95:0] cmd_t;
    cmd_t exp_q[$];

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 0;
    bit   ready_mode = 0;
    bit   model_relu = 0;
    int   cyc, hs_cnt, done_cnt, en_cnt, en_idx, last_hs_cyc;
    bit   prev_stall;
    cmd_t prev_cmd;
    logic [31:0] en_instr, last_instr, last_rs1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int f7, input int r2, input int r1, input int x, input int rd);
        return {7'(f7), 5'(r2), 5'(r1), 3'(x), 5'(rd), 7'b0001011};
    endfunction

    // Whole-layer command list built from the loop description of the sequence.
    task automatic build_model();
        int k, w, h, ntiles, acc;
        bit en;
        exp_q.delete();
        exp_q.push_back({enc(64, 0, 0, 0, 0), 32'd0, 32'd0});
        exp_q.push_back({enc(2, 0, 0, 3, 0), cfg0, cfg1});
        for (int i = 0; i < NUM_BASE; i += 2)
            exp_q.push_back({enc(1, 0, 0, 3, i), cfg_base[32*i +: 32], cfg_base[32*(i+1) +: 32]});
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < PES; p++)
                exp_q.push_back({enc(8, p, 0, 2, r), 32'd0, 32'd0});
        exp_q.push_back({enc(4, 0, 0, 3, 0), cfg_mat_vrs1, cfg_mat_vrs2});
        k = int'(cfg1[22:13]);
        w = int'(cfg_mat_vrs1[31:16]);
        h = int'(cfg_mat_vrs1[15:0]);
        ntiles = k * w * h;
        for (int t = 0; t < ntiles; t++)
            for (int r = 0; r < ROWS; r++) begin
                if (model_relu) begin
                    en  = (r == ROWS - 1) && (t != ntiles - 1);
                    acc = en ? (16 + r) : r;
                    exp_q.push_back({enc(32, acc, 0, 2, 0), cfg_relu_addr, 32'd0});
                end else begin
                    for (int p = 0; p < PES; p++) begin
                        en  = (r == ROWS - 1) && (p == PES - 1) && (t != ntiles - 1);
                        acc = en ? (16 + r) : r;
                        exp_q.push_back({enc(16, p, acc, 4, 0), 32'd0, 32'd0});
                    end
                end
            end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        cmd_ready = ready_mode ? ~cmd_ready : 1'b1;
    end

    // Compare process: every cycle while enabled.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            cyc++;
            if (prev_stall) begin
                check("hold_valid", cmd_valid, 1'b1);
                check("hold_cmd", {cmd_instr, cmd_rs1, cmd_rs2}, prev_cmd);
            end
            if (cmd_valid) check("busy_with_valid", busy, 1'b1);
            if (cmd_valid && cmd_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_cmd", hs_cnt, 0);
                end else begin
                    check($sformatf("cmd%0d", hs_cnt), {cmd_instr, cmd_rs1, cmd_rs2}, exp_q.pop_front());
                end
                if ((cmd_instr[31:25] == 7'd16 && cmd_instr[19:18] == 2'b10) ||
                    (cmd_instr[31:25] == 7'd32 && cmd_instr[24:23] == 2'b10)) begin
                    en_cnt++;
                    en_idx   = hs_cnt;
                    en_instr = cmd_instr;
                end
                last_instr  = cmd_instr;
                last_rs1    = cmd_rs1;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_timing", cyc, last_hs_cyc + 1);
                check("done_quiet", {cmd_valid, busy}, 2'b00);
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_cmd   = {cmd_instr, cmd_rs1, cmd_rs2};
        end
    end

    task automatic set_defaults();
        cfg0          = 32'h0040_0003;
        cfg1          = 32'h0000_2A05;
        cfg_mat_vrs1  = 32'h0001_0002;
        cfg_mat_vrs2  = 32'h0003_0004;
        for (int i = 0; i < NUM_BASE; i++) cfg_base[32*i +: 32] = 32'h1000_0000 + 32'(i * 32'h111);
        cfg_relu_addr = 32'h0000_0080;
        cfg_relu_mode = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic arm_monitor(input bit toggle);
        cyc = 0; hs_cnt = 0; done_cnt = 0; en_cnt = 0; en_idx = 0;
        last_hs_cyc = -10; prev_stall = 0;
        en_instr = '0; last_instr = '0; last_rs1 = '0;
        ready_mode = toggle;
        mon_en = 1'b1;
    endtask

    task automatic run_seq(input string tag, input int exp_n, input bit toggle, input bit disturb);
        logic [31:0]            s_cfg0, s_vrs1;
        logic [NUM_BASE*32-1:0] s_base;
        build_model();
        check({tag, "_model_len"}, exp_q.size(), exp_n);
        arm_monitor(toggle);
        pulse_start();
        if (disturb) begin
            s_cfg0 = cfg0; s_vrs1 = cfg_mat_vrs1; s_base = cfg_base;
            repeat (20) @(posedge clk);
            #1;
            start = 1'b1;
            cfg0 = 32'hDEAD_BEEF; cfg_mat_vrs1 = 32'h0005_0005; cfg_base = ~cfg_base;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (30) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            cfg0 = s_cfg0; cfg_mat_vrs1 = s_vrs1; cfg_base = s_base;
        end
        for (int c = 0; c < 5000 && done_cnt == 0; c++) @(posedge clk);
        check({tag, "_done_seen"}, done_cnt > 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hs_count"}, hs_cnt, exp_n);
        check({tag, "_model_drained"}, exp_q.size(), 0);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle_after"}, {cmd_valid, busy, done}, 3'b000);
        mon_en = 1'b0;
        ready_mode = 1'b0;
    endtask

    initial begin
        set_defaults();
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", {cmd_valid, busy, done, cmd_instr, cmd_rs1, cmd_rs2}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("after_reset", {cmd_valid, busy, done, cmd_instr, cmd_rs1, cmd_rs2}, '0);

        // Baseline racc layer, ready always high.
        run_seq("t1", 391, 0, 0);
        check("t1_en_cnt", en_cnt, 1);
        check("t1_en_idx", en_idx, 263);
        check("t1_en_instr", en_instr, 32'h20FB_C00B);
        check("t1_last_instr", last_instr, 32'h20F3_C00B);

        // Back-pressure every other cycle, with start re-pulsed and cfg scrambled while busy.
        run_seq("t2", 391, 1, 1);
        check("t2_en_idx", en_idx, 263);
        check("t2_last_instr", last_instr, 32'h20F3_C00B);

        // Zero H count: readout skipped.
        cfg_mat_vrs1 = 32'h0001_0000;
        run_seq("t3", 135, 0, 0);
        check("t3_en_cnt", en_cnt, 0);
        check("t3_last_instr", last_instr, 32'h0800_300B);
        cfg_mat_vrs1 = 32'h0001_0002;

`ifdef HWPE_SEQ_RELU_EN
        model_relu = 1'b1;
        cfg_relu_mode = 1'b1;
        cfg_relu_addr = 32'd128;
        run_seq("t4", 151, 0, 0);
        check("t4_en_cnt", en_cnt, 1);
        check("t4_en_idx", en_idx, 143);
        check("t4_en_instr", en_instr, 32'h4170_200B);
        check("t4_last_instr", last_instr, 32'h4070_200B);
        check("t4_relu_rs1", last_rs1, 32'h0000_0080);
        model_relu = 1'b0;
        cfg_relu_mode = 1'b0;
`else
        model_relu = 1'b0;
        cfg_relu_mode = 1'b1;
        run_seq("t4", 391, 0, 0);
        check("t4_en_idx", en_idx, 263);
        check("t4_last_instr", last_instr, 32'h20F3_C00B);
        cfg_relu_mode = 1'b0;
`endif

        // Reset while command #50 is presented, then a fresh start replays from RST.
        build_model();
        arm_monitor(1'b0);
        pulse_start();
        for (int c = 0; c < 300 && hs_cnt < 49; c++) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_at_cmd", hs_cnt, 50);
        check("t5_after_rst", {cmd_valid, busy, done, cmd_instr, cmd_rs1, cmd_rs2}, '0);
        exp_q.delete();
        run_seq("t5", 391, 0, 0);
        check("t5_en_idx", en_idx, 263);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
